// File: rtl/agc_io_channels.sv
// IO channel responder for the AGC core: keypad latch, status, display
// FIFO, two output latches and two synchronised input ports.
module agc_io_channels #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  IO_read_sel,
    input  logic [2:0]  IO_write_sel,
    input  logic [14:0] IO_write_data,
    output logic [14:0] IO_read_data,
    output logic        io_stall,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic [14:0] disp_data,
    output logic [14:0] out_ch4,
    output logic [14:0] out_ch5,
    input  logic [14:0] in_ch6,
    input  logic [14:0] in_ch7
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    key_q, key_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [14:0]   o4_q, o4_d;
    logic [14:0]   o5_q, o5_d;
    logic [14:0]   rd_q, rd_d;
    logic [14:0]   mem_q [FIFO_DEPTH];
    logic [14:0]   s6_q [SYNC_STAGES];
    logic [14:0]   s7_q [SYNC_STAGES];

    logic full, push, pop, rd_key;

    assign full       = (cnt_q == CW'(FIFO_DEPTH));
    assign io_stall   = (IO_write_sel == 3'd3) && full;
    assign push       = (IO_write_sel == 3'd3) && !full;
    assign disp_valid = (cnt_q != '0);
    assign pop        = disp_valid && disp_ready;
    assign disp_data  = disp_valid ? mem_q[rp_q] : 15'h0;
    assign rd_key     = (IO_read_sel == 3'd1);
    assign out_ch4    = o4_q;
    assign out_ch5    = o5_q;
    assign IO_read_data = rd_q;

    always_comb begin
        cnt_d = cnt_q;
        wp_d  = push ? wp_q + AW'(1) : wp_q;
        rp_d  = pop ? rp_q + AW'(1) : rp_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // A ch1 read frees the latch in the same cycle, so a coincident key is taken
    always_comb begin
        key_d  = key_q;
        pend_d = pend_q;
        ovr_d  = ovr_q;
        o4_d   = o4_q;
        o5_d   = o5_q;
        if (IO_write_sel == 3'd2) ovr_d = 1'b0;
        if (IO_write_sel == 3'd4) o4_d = IO_write_data;
        if (IO_write_sel == 3'd5) o5_d = IO_write_data;
        if (key_valid && (!pend_q || rd_key)) begin
            key_d  = key_code;
            pend_d = 1'b1;
        end else if (key_valid) begin
            ovr_d = 1'b1;
        end else if (rd_key) begin
            pend_d = 1'b0;
        end
    end

    always_comb begin
        rd_d = 15'h0;
        unique case (IO_read_sel)
            3'd1:    rd_d = {10'b0, key_q};
            3'd2:    rd_d = {12'b0, ovr_q, full, pend_q};
            3'd3:    rd_d = 15'(cnt_q);
            3'd4:    rd_d = o4_q;
            3'd5:    rd_d = o5_q;
            3'd6:    rd_d = s6_q[SYNC_STAGES-1];
            3'd7:    rd_d = s7_q[SYNC_STAGES-1];
            default: rd_d = 15'h0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_q  <= '0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            cnt_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            o4_q   <= '0;
            o5_q   <= '0;
            rd_q   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                s6_q[i] <= '0;
                s7_q[i] <= '0;
            end
        end else begin
            key_q  <= key_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            cnt_q  <= cnt_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            o4_q   <= o4_d;
            o5_q   <= o5_d;
            rd_q   <= rd_d;
            s6_q[0] <= in_ch6;
            s7_q[0] <= in_ch7;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                s6_q[i] <= s6_q[i-1];
                s7_q[i] <= s7_q[i-1];
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clock) begin
        if (push) mem_q[wp_q] <= IO_write_data;
    end

endmodule
